uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester transmit scheduler for a bus-attached UART: programs the baud
// divisors once, then polls the status register and writes queued bytes round-robin.
module uart_tx_sched #(
    parameter logic [15:0] DIV_R = 16'd325,
    parameter logic [15:0] DIV_T = 16'd5208,
    parameter int unsigned GUARD = 2
) (
    input  logic        CLK_I,
    input  logic        RST_N_I,

    input  logic        req0_valid_i,
    input  logic [7:0]  req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [7:0]  req1_data_i,
    output logic        req1_ready_o,

    output logic [6:2]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,

    output logic        init_done_o,
    output logic        busy_o,
    output logic        gnt_id_o
);

    localparam logic [6:2] ADDR_DATA   = 5'b00100;
    localparam logic [6:2] ADDR_STATUS = 5'b01000;
    localparam logic [6:2] ADDR_DIV_R  = 5'b01001;
    localparam logic [6:2] ADDR_DIV_T  = 5'b01010;
    localparam logic [3:0] GUARD_CNT   = 4'(GUARD);

    typedef enum logic [2:0] {
        S_INIT_R,
        S_INIT_T,
        S_IDLE,
        S_POLL,
        S_WRITE,
        S_GUARD
    } state_e;

    state_e     state_q, state_d;
    logic       active_q, active_d;
    logic [1:0] full_q, full_d;
    logic [7:0] slot0_q, slot0_d;
    logic [7:0] slot1_q, slot1_d;
    logic       last_q, last_d;
    logic       gnt_q, gnt_d;
    logic [3:0] guard_q, guard_d;
    logic       init_done_q, init_done_d;

    logic       stb;
    logic       bus_ack;
    logic       arb_pick;
    logic       take0, take1;
    logic       tx_ready;
    logic       unused_dat;

    // Only the transmit-holding-empty flag of the status word matters here.
    assign tx_ready   = DAT_I[5];
    assign unused_dat = ^{DAT_I[31:6], DAT_I[4:0]};

    // active_q is cleared asynchronously and set one clock after reset release,
    // so the bus strobe and the ready flags are low throughout reset.
    assign req0_ready_o = active_q & ~full_q[0];
    assign req1_ready_o = active_q & ~full_q[1];

    assign take0   = req0_valid_i & req0_ready_o;
    assign take1   = req1_valid_i & req1_ready_o;
    assign bus_ack = ACK_I & stb;

    // On a tie the requester not served last wins; a single full slot always wins.
    assign arb_pick = (full_q[0] & full_q[1]) ? ~last_q : full_q[1];

    assign init_done_o = init_done_q;
    assign busy_o      = (state_q != S_IDLE);
    assign gnt_id_o    = gnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block ordering.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= S_INIT_R;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT_R: if (bus_ack)             state_d = S_INIT_T;
            S_INIT_T: if (bus_ack)             state_d = S_IDLE;
            S_IDLE:   if (|full_q)             state_d = S_POLL;
            S_POLL:   if (bus_ack && tx_ready) state_d = S_WRITE;
            S_WRITE:  if (bus_ack)             state_d = S_GUARD;
            S_GUARD:  if (guard_q <= 4'd1)     state_d = S_IDLE;
            default:                           state_d = S_INIT_R;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        stb   = 1'b0;
        WE_O  = 1'b0;
        ADD_O = '0;
        DAT_O = '0;
        if (active_q) begin
            unique case (state_q)
                S_INIT_R: begin
                    stb   = 1'b1;
                    WE_O  = 1'b1;
                    ADD_O = ADDR_DIV_R;
                    DAT_O = {16'b0, DIV_R};
                end
                S_INIT_T: begin
                    stb   = 1'b1;
                    WE_O  = 1'b1;
                    ADD_O = ADDR_DIV_T;
                    DAT_O = {16'b0, DIV_T};
                end
                S_POLL: begin
                    stb   = 1'b1;
                    ADD_O = ADDR_STATUS;
                end
                S_WRITE: begin
                    stb   = 1'b1;
                    WE_O  = 1'b1;
                    ADD_O = ADDR_DATA;
                    DAT_O = {24'b0, gnt_q ? slot1_q : slot0_q};
                end
                default: ;
            endcase
        end
        STB_O = stb;
    end

    always_comb begin
        active_d    = 1'b1;
        full_d      = full_q;
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        guard_d     = guard_q;
        init_done_d = init_done_q;

        if (take0) begin
            full_d[0] = 1'b1;
            slot0_d   = req0_data_i;
        end
        if (take1) begin
            full_d[1] = 1'b1;
            slot1_d   = req1_data_i;
        end

        unique case (state_q)
            S_INIT_T: if (bus_ack) init_done_d = 1'b1;
            S_IDLE:   if (|full_q) gnt_d = arb_pick;
            S_WRITE: begin
                // A full slot cannot be taken, so clearing here never races a refill.
                if (bus_ack) begin
                    full_d[gnt_q] = 1'b0;
                    last_d        = gnt_q;
                    guard_d       = GUARD_CNT;
                end
            end
            S_GUARD:  if (guard_q != 4'd0) guard_d = guard_q - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            active_q    <= 1'b0;
            full_q      <= 2'b00;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            guard_q     <= 4'd0;
            init_done_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            full_q      <= full_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            guard_q     <= guard_d;
            init_done_q <= init_done_d;
        end
    end

    // NOTE: slot payloads carry no reset; the full flags alone decide whether a
    // byte is valid, so clearing them discards any held data.
    always_ff @(posedge CLK_I) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a bus responder logs every UART access and
// the main sequence compares outputs and the log against hand-computed values.
module tb_uart_tx_sched;

    logic        CLK_I = 1'b0;
    logic        RST_N_I = 1'b0;
    logic        req0_valid_i = 1'b0;
    logic [7:0]  req0_data_i = 8'h00;
    logic        req0_ready_o;
    logic        req1_valid_i = 1'b0;
    logic [7:0]  req1_data_i = 8'h00;
    logic        req1_ready_o;
    logic [6:2]  ADD_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I = 32'h0;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I = 1'b0;
    logic        init_done_o;
    logic        busy_o;
    logic        gnt_id_o;

    int checks = 0;
    int errors = 0;

    uart_tx_sched dut (
        .CLK_I        (CLK_I),
        .RST_N_I      (RST_N_I),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .ADD_O        (ADD_O),
        .DAT_O        (DAT_O),
        .DAT_I        (DAT_I),
        .STB_O        (STB_O),
        .WE_O         (WE_O),
        .ACK_I        (ACK_I),
        .init_done_o  (init_done_o),
        .busy_o       (busy_o),
        .gnt_id_o     (gnt_id_o)
    );

    always #5 CLK_I = ~CLK_I;

    // Bus responder state and access log.
    logic        in_acc = 1'b0;
    int          wait_cnt = 0;
    int          write_delay = 0;
    int          poll_not_ready = 0;
    logic [6:2]  acc_add;
    logic [31:0] acc_dat;
    logic        acc_we;
    int          rd_n = 0;
    int          wr_n = 0;
    int          init_n = 0;
    int          abort_n = 0;
    int          unstable_n = 0;
    int          early_wr_n = 0;
    int          rd_at_wr = 0;
    int          last_wr_len = 0;
    logic [31:0] wr_log [32];
    logic [6:2]  init_add [8];
    logic [31:0] init_dat [8];

    always @(negedge CLK_I) begin
        ACK_I = 1'b0;
        DAT_I = 32'h0;
        if (!STB_O) begin
            if (in_acc && RST_N_I) abort_n++;
            in_acc = 1'b0;
        end else begin
            if (!in_acc) begin
                in_acc   = 1'b1;
                wait_cnt = 0;
                acc_add  = ADD_O;
                acc_dat  = DAT_O;
                acc_we   = WE_O;
            end else begin
                if (ADD_O !== acc_add || DAT_O !== acc_dat || WE_O !== acc_we) unstable_n++;
                wait_cnt++;
            end
            if (wait_cnt >= ((ADD_O == 5'b00100) ? write_delay : 0)) begin
                ACK_I  = 1'b1;
                in_acc = 1'b0;
                if (!WE_O && ADD_O == 5'b01000) begin
                    rd_n++;
                    if (poll_not_ready > 0) begin
                        poll_not_ready--;
                        DAT_I = 32'hFFFF_FFDF;
                    end else begin
                        DAT_I = 32'h0000_0020;
                    end
                end else if (WE_O && ADD_O == 5'b00100) begin
                    if (!init_done_o) early_wr_n++;
                    if (wr_n < 32) wr_log[wr_n] = DAT_O;
                    wr_n++;
                    rd_at_wr    = rd_n;
                    last_wr_len = wait_cnt + 1;
                end else if (WE_O) begin
                    init_add[init_n % 8] = ADD_O;
                    init_dat[init_n % 8] = DAT_O;
                    init_n++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wait_ready(input int r, input string tag);
        int n = 0;
        while (((r == 0) ? req0_ready_o : req1_ready_o) !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic send(input int r, input logic [7:0] b);
        wait_ready(r, $sformatf("send%0d_ready_timeout", r));
        if (r == 0) begin
            req0_valid_i = 1'b1;
            req0_data_i  = b;
        end else begin
            req1_valid_i = 1'b1;
            req1_data_i  = b;
        end
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string tag);
        int n = 0;
        while (!(wr_n >= target && busy_o === 1'b0) && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 500), 32'd1);
    endtask

    initial begin
        int rd0;
        int n;

        // Reset state.
        RST_N_I = 1'b0;
        repeat (3) tick();
        check("rst_stb", STB_O, 0);
        check("rst_we", WE_O, 0);
        check("rst_add", ADD_O, 0);
        check("rst_ready0", req0_ready_o, 0);
        check("rst_ready1", req1_ready_o, 0);
        check("rst_init_done", init_done_o, 0);
        check("rst_gnt", gnt_id_o, 0);
        check("rst_busy", busy_o, 1);

        // Divisor programming with zero-wait acknowledges.
        RST_N_I = 1'b1;
        tick();
        check("init_ready0", req0_ready_o, 1);
        check("init_ready1", req1_ready_o, 1);
        check("init_r_stb", STB_O, 1);
        check("init_r_we", WE_O, 1);
        check("init_r_add", ADD_O, 5'b01001);
        check("init_r_dat", DAT_O, 32'h0000_0145);
        tick();
        check("init_t_add", ADD_O, 5'b01010);
        check("init_t_dat", DAT_O, 32'h0000_1458);
        check("init_t_done", init_done_o, 0);
        tick();
        check("init_done", init_done_o, 1);
        check("init_idle", busy_o, 0);
        check("idle_stb", STB_O, 0);
        check("idle_dat", DAT_O, 0);
        check("init_count", init_n, 2);
        check("init_log0_add", init_add[0], 5'b01001);
        check("init_log1_dat", init_dat[1], 32'h0000_1458);

        // Tie after init goes to requester 0; refilled slot 0 then loses the tie.
        req0_valid_i = 1'b1;
        req0_data_i  = 8'h11;
        req1_valid_i = 1'b1;
        req1_data_i  = 8'h22;
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        check("tie_ready0_low", req0_ready_o, 0);
        check("tie_ready1_low", req1_ready_o, 0);
        wait_ready(0, "refill_ready_timeout");
        send(0, 8'h33);
        wait_writes(3, "rr_timeout");
        check("rr_first", wr_log[0], 32'h11);
        check("rr_second", wr_log[1], 32'h22);
        check("rr_third", wr_log[2], 32'h33);
        check("rr_gnt", gnt_id_o, 0);

        // Single byte: one poll, one write, two guard cycles.
        rd0 = rd_n;
        send(0, 8'h41);
        tick();
        check("b41_poll_stb", STB_O, 1);
        check("b41_poll_add", ADD_O, 5'b01000);
        check("b41_poll_we", WE_O, 0);
        check("b41_gnt", gnt_id_o, 0);
        tick();
        check("b41_wr_add", ADD_O, 5'b00100);
        check("b41_wr_we", WE_O, 1);
        check("b41_wr_dat", DAT_O, 32'h0000_0041);
        check("b41_wr_ready0", req0_ready_o, 0);
        tick();
        check("b41_guard1_stb", STB_O, 0);
        check("b41_guard1_busy", busy_o, 1);
        check("b41_ready0_back", req0_ready_o, 1);
        tick();
        check("b41_guard2_busy", busy_o, 1);
        tick();
        check("b41_idle", busy_o, 0);
        check("b41_wr_count", wr_n, 4);
        check("b41_wr_log", wr_log[3], 32'h0000_0041);
        check("b41_rd_count", rd_n - rd0, 1);

        // Five busy polls, then ready: six reads and exactly one write after them.
        poll_not_ready = 5;
        rd0 = rd_n;
        send(1, 8'h5C);
        wait_writes(5, "poll_timeout");
        check("poll_reads_before_wr", rd_at_wr - rd0, 6);
        check("poll_reads_total", rd_n - rd0, 6);
        check("poll_wr_count", wr_n, 5);
        check("poll_wr_log", wr_log[4], 32'h0000_005C);
        check("poll_gnt", gnt_id_o, 1);

        // Acknowledge held off three cycles on the data write.
        write_delay = 3;
        send(0, 8'hA5);
        wait_writes(6, "slow_ack_timeout");
        write_delay = 0;
        check("slow_len", last_wr_len, 4);
        check("slow_stable", unstable_n, 0);
        check("slow_wr_count", wr_n, 6);
        check("slow_wr_log", wr_log[5], 32'h0000_00A5);

        // Reset in the middle of polling discards the held byte and reruns init.
        poll_not_ready = 1000;
        send(1, 8'h99);
        n = 0;
        while (!(STB_O === 1'b1 && ADD_O === 5'b01000) && n < 50) begin
            tick();
            n++;
        end
        check("mid_rst_poll_timeout", 32'(n < 50), 32'd1);
        repeat (2) tick();
        RST_N_I = 1'b0;
        #1;
        check("mid_rst_stb", STB_O, 0);
        check("mid_rst_we", WE_O, 0);
        check("mid_rst_ready1", req1_ready_o, 0);
        check("mid_rst_init_done", init_done_o, 0);
        repeat (2) tick();
        poll_not_ready = 0;
        RST_N_I = 1'b1;
        tick();
        check("rerun_ready1", req1_ready_o, 1);
        check("rerun_add_r", ADD_O, 5'b01001);
        req0_valid_i = 1'b1;
        req0_data_i  = 8'h5A;
        tick();
        req0_valid_i = 1'b0;
        check("rerun_add_t", ADD_O, 5'b01010);
        check("rerun_not_done", init_done_o, 0);
        check("rerun_ready0_full", req0_ready_o, 0);
        wait_writes(7, "rerun_timeout");
        check("rerun_init_count", init_n, 4);
        check("rerun_wr_count", wr_n, 7);
        check("rerun_wr_log", wr_log[6], 32'h0000_005A);
        repeat (5) tick();
        check("rerun_no_stale", wr_n, 7);
        check("early_writes", early_wr_n, 0);
        check("aborted_accesses", abort_n, 0);
        check("unstable_accesses", unstable_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
